// File: rtl/inst_decode_stage.sv
// RV32I decode stage: fetches the word at the fetch PC over a valid handshake with a
// bounded wait, then registers decoded fields/controls and pulses ID_kick_up to execute.
module inst_decode_stage #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_kick_up,
  input  logic [31:0] inst_mem_read_addr,
  input  logic [31:0] inst_mem_rdata,
  input  logic        inst_mem_valid,
  output logic        inst_mem_req,
  output logic        ID_kick_up,
  output logic [31:0] id_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imme,
  output logic        Controller_branch,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic        illegal_inst,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StDecode} state_e;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [31:0]      NopInst     = 32'h0000_0013;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;
  logic             timeout_hit;
  logic [31:0]      inst_word;

  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imme;
  logic        dec_branch, dec_alu_src_imm, dec_reg_write, dec_mem_read, dec_mem_write;
  logic [3:0]  dec_alu_op;
  logic        dec_illegal;

  assign inst_mem_req = (state_q == StWaitMem);
  assign ID_kick_up   = (state_q == StDecode);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      StIdle: begin
        if (IF_kick_up) begin
          state_d = StWaitMem;
          cnt_d   = '0;
        end
      end
      StWaitMem: begin
        // valid in the final allowed cycle still counts as a normal response
        if (inst_mem_valid) begin
          capture = 1'b1;
          state_d = StDecode;
        end else if (cnt_q == TimeoutLast) begin
          capture     = 1'b1;
          timeout_hit = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          state_d     = StDecode;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign inst_word = timeout_hit ? NopInst : inst_mem_rdata;

  always_comb begin
    dec_rs1         = '0;
    dec_rs2         = '0;
    dec_rd          = '0;
    dec_imme        = '0;
    dec_branch      = 1'b0;
    dec_alu_src_imm = 1'b0;
    dec_reg_write   = 1'b0;
    dec_mem_read    = 1'b0;
    dec_mem_write   = 1'b0;
    dec_alu_op      = '0;
    dec_illegal     = 1'b0;
    case (inst_word[6:0])
      OpR: begin
        dec_rs1       = inst_word[19:15];
        dec_rs2       = inst_word[24:20];
        dec_rd        = inst_word[11:7];
        dec_reg_write = 1'b1;
        dec_alu_op    = {inst_word[30], inst_word[14:12]};
      end
      OpImm, OpLoad: begin
        dec_rs1         = inst_word[19:15];
        dec_rd          = inst_word[11:7];
        dec_imme        = {{20{inst_word[31]}}, inst_word[31:20]};
        dec_reg_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        dec_mem_read    = (inst_word[6:0] == OpLoad);
        dec_alu_op      = {1'b0, inst_word[14:12]};
      end
      OpStore: begin
        dec_rs1         = inst_word[19:15];
        dec_rs2         = inst_word[24:20];
        dec_imme        = {{20{inst_word[31]}}, inst_word[31:25], inst_word[11:7]};
        dec_mem_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        dec_alu_op      = {1'b0, inst_word[14:12]};
      end
      OpBranch: begin
        if (inst_word[14:12] == 3'b000) begin
          dec_rs1    = inst_word[19:15];
          dec_rs2    = inst_word[24:20];
          // offset kept in halfword units: bit 0 of the byte offset is implicit
          dec_imme   = {{20{inst_word[31]}}, inst_word[31], inst_word[7],
                        inst_word[30:25], inst_word[11:8]};
          dec_branch = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpLui: begin
        dec_rd          = inst_word[11:7];
        dec_imme        = {inst_word[31:12], 12'b0};
        dec_reg_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      id_pc             <= '0;
      rs1               <= '0;
      rs2               <= '0;
      rd                <= '0;
      imme              <= '0;
      Controller_branch <= 1'b0;
      alu_src_imm       <= 1'b0;
      reg_write         <= 1'b0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      alu_op            <= '0;
      illegal_inst      <= 1'b0;
      mem_timeout       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && IF_kick_up) begin
        id_pc <= inst_mem_read_addr;
      end
      if (capture) begin
        rs1               <= dec_rs1;
        rs2               <= dec_rs2;
        rd                <= dec_rd;
        imme              <= dec_imme;
        Controller_branch <= dec_branch;
        alu_src_imm       <= dec_alu_src_imm;
        reg_write         <= dec_reg_write;
        mem_read          <= dec_mem_read;
        mem_write         <= dec_mem_write;
        alu_op            <= dec_alu_op;
        if (dec_illegal) begin
          illegal_inst <= 1'b1;
        end
      end
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule
